key_entry_sched: RTL and testbench

//  Shares one DecInputKey decoder between N_REQ key-entry requesters. Round-robin grant,

---
 rtl/key_sched_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 38 +++
 rtl/key_entry_sched.sv | 247 ++++++++++++++++++++++++
 tb/tb_key_entry_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/key_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_sched_pkg
// Purpose  : Shared definitions for the key-entry scheduler: one-hot FSM
//            state encoding, state width and a helper that derives counter
//            widths from a modulus.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package key_sched_pkg;

  localparam int c_state_w = 7;

  typedef enum logic [c_state_w-1:0] {
    ST_IDLE   = 7'b000_0001,
    ST_CLR    = 7'b000_0010,
    ST_SHIFT  = 7'b000_0100,
    ST_MODE   = 7'b000_1000,
    ST_WAIT   = 7'b001_0000,
    ST_RESULT = 7'b010_0000,
    ST_LOCK   = 7'b100_0000
  } state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. The search for a requester
//            starts at i_ptr and wraps; the first active request wins.
// Ports    : i_req   [N_REQ] request vector
//            i_ptr   [PTR_W] index at which the search starts
//            i_en            arbitration enable; grant is zero when low
//            o_grant [N_REQ] one-hot winner, zero when none / disabled
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import key_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PTR_W = cnt_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_grant
);

  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (i_en && !w_found && i_req[(int'(i_ptr) + k) % N_REQ]) begin
        o_grant[(int'(i_ptr) + k) % N_REQ] = 1'b1;
        w_found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_entry_sched.sv
`default_nettype none
// ============================================================================
// Module   : key_entry_sched
// Purpose  : Shares one DecInputKey decoder between N_REQ key-entry
//            requesters. Round-robin grant, decoder clear, bit-serial key and
//            mode streaming on ValidCmd, Active polling with timeout, and a
//            one-cycle pass/fail result.
//            Optional build macro KEY_LOCKOUT_EN: after MAX_FAIL consecutive
//            failures the block locks out all requesters for LOCK_CYC cycles.
// Ports    : Clk, Reset (async, active-high)
//            req[N_REQ], key_word[N_REQ*KEY_W], mode_bit[N_REQ] - requesters
//            grant[N_REQ] one-hot owner; done/pass result pulse; busy
//            InputKey, ValidCmd, DecReset - to decoder
//            Active, Mode                 - from decoder
//            locked - lockout in progress (tied 0 without KEY_LOCKOUT_EN)
// Revision : 1.0 - initial release
// ============================================================================
module key_entry_sched
  import key_sched_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int KEY_W    = 4,
  parameter int TIMEOUT  = 8,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYC = 64
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*KEY_W-1:0] key_word,
  input  logic [N_REQ-1:0]       mode_bit,
  output logic [N_REQ-1:0]       grant,
  output logic                   done,
  output logic                   pass,
  output logic                   busy,
  output logic                   InputKey,
  output logic                   ValidCmd,
  output logic                   DecReset,
  input  logic                   Active,
  input  logic                   Mode,
  output logic                   locked
);

  localparam int c_own_w  = cnt_w(N_REQ);
  localparam int c_idx_w  = cnt_w(KEY_W);
  localparam int c_tmr_w  = cnt_w(TIMEOUT);

  state_t               r_state;
  state_t               w_next;
  logic [c_own_w-1:0]   r_owner;
  logic [c_own_w-1:0]   r_ptr;
  logic [c_idx_w-1:0]   r_bit_idx;
  logic [c_tmr_w-1:0]   r_timer;
  logic                 r_pass;
  logic                 r_rst_pulse;
  logic                 w_pass_nxt;

  logic [N_REQ-1:0]     w_arb_grant;
  logic                 w_arb_valid;
  logic [c_own_w-1:0]   w_arb_idx;
  logic                 w_own_req;
  logic                 w_own_mode;
  logic [KEY_W-1:0]     w_own_key;
  logic                 w_owned;
  logic                 w_lock_now;
  logic                 w_lock_done;

  // --------------------------------------------------------------------------
  // Arbitration (only meaningful while idle)
  // --------------------------------------------------------------------------
  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (c_own_w)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .i_en    (r_state == ST_IDLE),
    .o_grant (w_arb_grant)
  );

  assign w_arb_valid = |w_arb_grant;

  always_comb begin
    w_arb_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_arb_grant[i]) begin
        w_arb_idx = c_own_w'(i);
      end
    end
  end

  // Owner's inputs are used live; the requester holds them stable while granted.
  assign w_own_req  = req[r_owner];
  assign w_own_mode = mode_bit[r_owner];
  assign w_own_key  = key_word[r_owner*KEY_W +: KEY_W];

  // --------------------------------------------------------------------------
  // FSM next state. A dropped owner request aborts any in-flight phase and
  // takes priority over a decoder response in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    w_pass_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) w_next = ST_CLR;
      end
      ST_CLR: begin
        w_next = w_own_req ? ST_SHIFT : ST_RESULT;
      end
      ST_SHIFT: begin
        if (!w_own_req)               w_next = ST_RESULT;
        else if (r_bit_idx == '0)     w_next = ST_MODE;
      end
      ST_MODE: begin
        w_next = w_own_req ? ST_WAIT : ST_RESULT;
      end
      ST_WAIT: begin
        if (!w_own_req) begin
          w_next = ST_RESULT;
        end else if (Active) begin
          w_next     = ST_RESULT;
          w_pass_nxt = (Mode == w_own_mode);
        end else if (r_timer == c_tmr_w'(TIMEOUT - 1)) begin
          w_next = ST_RESULT;
        end
      end
      ST_RESULT: begin
        w_next = w_lock_now ? ST_LOCK : ST_IDLE;
      end
      ST_LOCK: begin
        if (w_lock_done) w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_bit_idx   <= '0;
      r_timer     <= '0;
      r_pass      <= 1'b0;
      r_rst_pulse <= 1'b1;
    end else begin
      r_state     <= w_next;
      // r_pass is only non-zero during RESULT; it is captured on the way in.
      r_pass      <= w_pass_nxt;
      r_rst_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) r_owner <= w_arb_idx;
        end
        ST_CLR: begin
          r_bit_idx <= c_idx_w'(KEY_W - 1);
        end
        ST_SHIFT: begin
          if (r_bit_idx != '0) r_bit_idx <= r_bit_idx - 1'b1;
        end
        ST_MODE: begin
          r_timer <= '0;
        end
        ST_WAIT: begin
          r_timer <= r_timer + 1'b1;
        end
        ST_RESULT: begin
          r_ptr <= (r_owner == c_own_w'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Optional lockout after repeated failures
  // --------------------------------------------------------------------------
`ifdef KEY_LOCKOUT_EN
  localparam int c_fail_w = cnt_w(MAX_FAIL + 1);
  localparam int c_lck_w  = cnt_w(LOCK_CYC);

  logic [c_fail_w-1:0] r_fail_cnt;
  logic [c_lck_w-1:0]  r_lock_tmr;
  logic [c_fail_w-1:0] w_fail_inc;

  assign w_fail_inc  = (r_fail_cnt == c_fail_w'(MAX_FAIL)) ? r_fail_cnt
                                                            : r_fail_cnt + 1'b1;
  assign w_lock_now  = !r_pass && (w_fail_inc == c_fail_w'(MAX_FAIL));
  assign w_lock_done = (r_lock_tmr == c_lck_w'(LOCK_CYC - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fail_cnt <= '0;
      r_lock_tmr <= '0;
    end else begin
      case (r_state)
        ST_RESULT: begin
          r_fail_cnt <= r_pass ? '0 : w_fail_inc;
          r_lock_tmr <= '0;
        end
        ST_LOCK: begin
          r_lock_tmr <= r_lock_tmr + 1'b1;
          if (w_lock_done) r_fail_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign locked = (r_state == ST_LOCK);
`else
  logic w_unused_cfg;

  assign w_lock_now   = 1'b0;
  assign w_lock_done  = 1'b1;
  assign locked       = 1'b0;
  assign w_unused_cfg = ((MAX_FAIL + LOCK_CYC) != 0);
`endif

  // --------------------------------------------------------------------------
  // Outputs (decoded from state so an async reset clears them immediately)
  // --------------------------------------------------------------------------
  assign w_owned  = (r_state == ST_CLR)  || (r_state == ST_SHIFT) ||
                    (r_state == ST_MODE) || (r_state == ST_WAIT)  ||
                    (r_state == ST_RESULT);
  assign grant    = w_owned ? (N_REQ'(1) << r_owner) : '0;
  assign done     = (r_state == ST_RESULT);
  assign pass     = r_pass;
  assign busy     = (r_state != ST_IDLE);
  assign ValidCmd = (r_state == ST_SHIFT) || (r_state == ST_MODE);
  // Decoder clear covers the reset period, one cycle after it, and CLR.
  assign DecReset = r_rst_pulse || (r_state == ST_CLR);

  always_comb begin
    InputKey = 1'b0;
    if (r_state == ST_SHIFT)     InputKey = w_own_key[r_bit_idx];
    else if (r_state == ST_MODE) InputKey = w_own_mode;
  end

endmodule
`default_nettype wire

// File: tb/tb_key_entry_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_key_entry_sched
// Purpose  : Self-checking bench for key_entry_sched. Directed scenarios
//            followed by randomized attempts, checked against a
//            transaction-level model (round-robin pick, expected bit stream,
//            expected completion cycle and verdict).
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_entry_sched;

  localparam int N  = 2;
  localparam int KW = 4;
  localparam int TO = 8;
  localparam int MF = 3;
  localparam int LC = 64;

  logic            Clk      = 1'b0;
  logic            Reset    = 1'b1;
  logic [N-1:0]    req      = '0;
  logic [N*KW-1:0] key_word = '0;
  logic [N-1:0]    mode_bit = '0;
  logic            Active   = 1'b0;
  logic            Mode     = 1'b0;
  logic [N-1:0]    grant;
  logic            done, pass, busy, InputKey, ValidCmd, DecReset, locked;

  int n_checks = 0;
  int n_err    = 0;
  int m_ptr    = 0;
  int m_fail   = 0;

  key_entry_sched #(
    .N_REQ (N), .KEY_W (KW), .TIMEOUT (TO), .MAX_FAIL (MF), .LOCK_CYC (LC)
  ) dut (
    .Clk (Clk), .Reset (Reset), .req (req), .key_word (key_word),
    .mode_bit (mode_bit), .grant (grant), .done (done), .pass (pass),
    .busy (busy), .InputKey (InputKey), .ValidCmd (ValidCmd),
    .DecReset (DecReset), .Active (Active), .Mode (Mode), .locked (locked)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One attempt. act_w: WAIT cycle (1..TO) in which the decoder raises Active,
  // 0 = never. abort_at: cycle offset from grant at which the owner drops req
  // (0..KW+1), -1 = no abort.
  task automatic serve(input int act_w, input logic dec_mode, input int abort_at, input string nm);
    int own, g, rel, done_rel, nbits, exp_done, exp_bits;
    logic [KW:0] got, exp_stream;
    logic [N-1:0] own_oh, gnt_at_done;
    logic done_pass, exp_pass, vc_at_done, gap;
    own = rr_pick(req, m_ptr);
    check({nm, "/has_req"}, (own >= 0), 1);
    if (own < 0) return;
    own_oh = '0; own_oh[own] = 1'b1;
    exp_stream = {key_word[own*KW +: KW], mode_bit[own]};
    g = -1; done_rel = -1; nbits = 0; got = '0; gap = 1'b0;
    done_pass = 1'b0; gnt_at_done = '0; vc_at_done = 1'b0;

    // Expected outcome: earliest of abort, decoder response, timeout.
    exp_done = KW + 2 + TO;
    exp_pass = 1'b0;
    if (act_w > 0) begin
      exp_done = KW + 2 + act_w;
      exp_pass = (dec_mode == mode_bit[own]);
    end
    if (abort_at >= 0) begin
      exp_done = abort_at + 1;
      exp_pass = 1'b0;
    end
    exp_bits = (abort_at >= 0) ? abort_at : KW + 1;

    for (int n = 0; n < 80 && done_rel < 0; n++) begin
      @(posedge Clk); #1;
      if (g < 0 && grant != '0) begin
        g = n;
        check({nm, "/grant"}, grant, own_oh);
        check({nm, "/clr"}, DecReset, 1);
      end
      rel = (g < 0) ? -1 : n - g;
      if (g >= 0) begin
        if (ValidCmd) begin
          if (rel != nbits + 1) gap = 1'b1;
          got = {got[KW-1:0], InputKey};
          nbits++;
        end
        if (done) begin
          done_rel = rel; done_pass = pass; gnt_at_done = grant; vc_at_done = ValidCmd;
        end
        if (rel == abort_at) req[own] = 1'b0;
      end
      // Decoder model: one Active pulse at the chosen WAIT cycle; random noise
      // on Active before WAIT, which the scheduler must ignore.
      if (g >= 0 && act_w > 0 && rel == KW + 1 + act_w) begin
        Active = 1'b1; Mode = dec_mode;
      end else if (g < 0 || rel < KW + 2) begin
        Active = 1'($urandom_range(0, 1)); Mode = 1'($urandom_range(0, 1));
      end else begin
        Active = 1'b0; Mode = 1'($urandom_range(0, 1));
      end
    end

    check({nm, "/done_cycle"}, done_rel, exp_done);
    check({nm, "/pass"}, done_pass, exp_pass);
    check({nm, "/nbits"}, nbits, exp_bits);
    check({nm, "/stream"}, got, exp_stream >> (KW + 1 - exp_bits));
    check({nm, "/gap"}, gap, 0);
    check({nm, "/grant_at_done"}, gnt_at_done, own_oh);
    check({nm, "/vc_at_done"}, vc_at_done, 0);

    req[own] = 1'b0;
    Active = 1'b0;
    m_ptr = (own + 1) % N;
`ifdef KEY_LOCKOUT_EN
    if (exp_pass) m_fail = 0; else m_fail++;
    if (m_fail >= MF) begin
      int lk, gk;
      lk = 0; gk = 0;
      req = '1;
      for (int k = 0; k < LC; k++) begin
        @(posedge Clk); #1;
        if (locked) lk++;
        if (grant != '0) gk++;
      end
      check({nm, "/lock_len"}, lk, LC);
      check({nm, "/lock_grant"}, gk, 0);
      @(posedge Clk); #1;
      check({nm, "/lock_end"}, locked, 0);
      m_fail = 0;
      return;
    end
`endif
    @(posedge Clk); #1;
    check({nm, "/idle_after"}, {grant, done, busy, locked}, 0);
  endtask

  initial begin
    int cnt;
    // ---------------- reset values ----------------
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst/grant", grant, 0);
    check("rst/flags", {done, pass, busy, InputKey, ValidCmd, locked}, 0);
    check("rst/decreset", DecReset, 1);
    Reset = 1'b0; #1;
    check("rst/decreset_hold", DecReset, 1);
    @(posedge Clk); #1;
    check("rst/decreset_drop", DecReset, 0);

    // ---------------- directed ----------------
    key_word = {4'b0000, 4'b1010}; mode_bit = 2'b01; req = 2'b01;
    serve(2, 1'b1, -1, "dir_1010");
    key_word = {4'b0110, 4'b0000}; mode_bit = 2'b00; req = 2'b10;
    serve(3, 1'b0, -1, "dir_req1");
    key_word = {4'b1100, 4'b0011}; mode_bit = 2'b10; req = 2'b11;
    serve(1, 1'b1, -1, "dir_both_a");
    serve(4, 1'b0, -1, "dir_both_b");
    req = 2'b01;
    serve(0, 1'b0, -1, "dir_timeout");
    req = 2'b10;
    serve(TO, 1'b1, -1, "dir_last_wait");
    req = 2'b01; mode_bit = 2'b01;
    serve(3, 1'b1, 2, "dir_abort");

    // ---------------- reset during WAIT ----------------
    req = 2'b01; Active = 1'b0; cnt = 0;
    for (int n = 0; n < 40 && cnt < KW + 1; n++) begin
      @(posedge Clk); #1;
      if (ValidCmd) cnt++;
    end
    check("rstw/strobes", cnt, KW + 1);
    @(posedge Clk); #1;
    check("rstw/in_wait", {busy, ValidCmd}, 2'b10);
    Reset = 1'b1; #1;
    check("rstw/grant", grant, 0);
    check("rstw/flags", {done, pass, busy, InputKey, ValidCmd, locked}, 0);
    check("rstw/decreset", DecReset, 1);
    req = '0;
    @(posedge Clk); #1;
    Reset = 1'b0; #1;
    check("rstw/decreset_hold", DecReset, 1);
    @(posedge Clk); #1;
    check("rstw/idle", {DecReset, busy}, 0);
    m_ptr = 0; m_fail = 0;
    key_word = {4'b1001, 4'b0101}; mode_bit = 2'b11; req = 2'b11;
    serve(2, 1'b1, -1, "post_rst_a");
    serve(5, 1'b1, -1, "post_rst_b");

    // ---------------- randomized ----------------
    for (int it = 0; it < 30; it++) begin
      key_word = (N*KW)'($urandom);
      mode_bit = N'($urandom);
      req      = req | N'($urandom_range(1, (1 << N) - 1));
      serve(int'($urandom_range(0, TO)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, KW + 1)) : -1,
            "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
